// File: rtl/desampling.sv
// desampling: rebuilds a frame from a sample list.
// The frame region is zero-filled first. Then each sample record
// {pixel index, pixel value} is merged into its 16-bit half of a packed
// frame word with a read-modify-write. Both SRAMs are driven directly.
// SRAM strobes and addresses are decoded combinationally from the state
// and from the latched record. done/err are registered flags.
module desampling #(
    parameter int AW = 14,
    parameter int DW = 32,
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [AW-1:0] sample_count,
    input  logic [AW-1:0] frame_words,
    output logic          done,
    output logic          err,
    output logic          sload,
    output logic [AW-1:0] saddr,
    input  logic [DW-1:0] sdata,
    output logic          fload,
    output logic          fstore,
    output logic [AW-1:0] faddr,
    input  logic [DW-1:0] fdata_in,
    output logic [DW-1:0] fdata_out
);

    // Pixel lanes per word, and the index bits that select a lane.
    localparam int LANES = DW / PW;
    localparam int LB    = $clog2(LANES);
    // The index field fills the upper half of a sample record.
    localparam int IW    = DW - PW;

    localparam logic [AW-1:0] ONE = AW'(1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RD_S,
        RD_F,
        WR_F,
        FIN
    } state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] fw_reg, fw_next;
    logic [AW-1:0] sc_reg, sc_next;
    logic [AW-1:0] i_reg, i_next;
    logic [AW-1:0] j_reg, j_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic [PW-1:0] val_reg, val_next;
    logic          done_reg, done_next;
    logic          err_reg, err_next;

    // Word index of the incoming sample record, at full width.
    // The range check uses all of its bits; truncation to AW bits happens
    // only when the address is driven.
    logic [IW-LB-1:0] sword;
    logic             in_range;
    logic [DW-1:0]    merged;

    assign sword    = sdata[DW-1:PW+LB];
    assign in_range = (32'(sword) < 32'(fw_reg));

    // Merge the latched pixel into its lane; the other lanes keep the
    // word just read from the frame SRAM.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign merged[gi*PW +: PW] = (idx_reg[LB-1:0] == LB'(gi))
                                         ? val_reg
                                         : fdata_in[gi*PW +: PW];
        end
    endgenerate

    assign done = done_reg;
    assign err  = err_reg;

    // State, latched job parameters, counters, latched record and flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            fw_reg    <= '0;
            sc_reg    <= '0;
            i_reg     <= '0;
            j_reg     <= '0;
            idx_reg   <= '0;
            val_reg   <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            fw_reg    <= fw_next;
            sc_reg    <= sc_next;
            i_reg     <= i_next;
            j_reg     <= j_next;
            idx_reg   <= idx_next;
            val_reg   <= val_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    // Next-state logic and SRAM strobes; strobes are inactive by default.
    always_comb begin
        state_next = state_reg;
        fw_next    = fw_reg;
        sc_next    = sc_reg;
        i_next     = i_reg;
        j_next     = j_reg;
        idx_next   = idx_reg;
        val_next   = val_reg;
        done_next  = done_reg;
        err_next   = err_reg;
        sload      = 1'b0;
        saddr      = '0;
        fload      = 1'b0;
        fstore     = 1'b1;
        faddr      = '0;
        fdata_out  = '0;

        case (state_reg)
            IDLE: begin
                if (enable) begin
                    fw_next   = frame_words;
                    sc_next   = sample_count;
                    done_next = 1'b0;
                    err_next  = 1'b0;
                    i_next    = '0;
                    j_next    = '0;
                    if (frame_words != '0) begin
                        state_next = CLEAR;
                    end else if (sample_count != '0) begin
                        state_next = RD_S;
                    end else begin
                        state_next = FIN;
                    end
                end
            end

            CLEAR: begin
                faddr  = i_reg;
                fstore = 1'b0;
                if (i_reg == fw_reg - ONE) begin
                    state_next = (sc_reg != '0) ? RD_S : FIN;
                end else begin
                    i_next = i_reg + ONE;
                end
            end

            RD_S: begin
                saddr      = j_reg;
                sload      = 1'b1;
                state_next = RD_F;
            end

            RD_F: begin
                idx_next = sdata[DW-1:PW];
                val_next = sdata[PW-1:0];
                if (in_range) begin
                    faddr      = AW'(sword);
                    fload      = 1'b1;
                    state_next = WR_F;
                end else begin
                    err_next = 1'b1;
                    if (j_reg == sc_reg - ONE) begin
                        state_next = FIN;
                    end else begin
                        j_next     = j_reg + ONE;
                        state_next = RD_S;
                    end
                end
            end

            WR_F: begin
                faddr     = AW'(idx_reg >> LB);
                fstore    = 1'b0;
                fdata_out = merged;
                if (j_reg == sc_reg - ONE) begin
                    state_next = FIN;
                end else begin
                    j_next     = j_reg + ONE;
                    state_next = RD_S;
                end
            end

            FIN: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_desampling.sv
// Bench for desampling: behavioural SRAM models, a write scoreboard fed by
// a small reference model, and directed steps with latency and frame checks.
module tb_desampling;

    localparam int AW = 14;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic [AW-1:0] sample_count = '0;
    logic [AW-1:0] frame_words = '0;
    logic          done, err, sload, fload, fstore;
    logic [AW-1:0] saddr, faddr;
    logic [DW-1:0] sdata, fdata_in, fdata_out;

    desampling #(.AW(AW), .DW(DW), .PW(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sample_count (sample_count),
        .frame_words  (frame_words),
        .done         (done),
        .err          (err),
        .sload        (sload),
        .saddr        (saddr),
        .sdata        (sdata),
        .fload        (fload),
        .fstore       (fstore),
        .faddr        (faddr),
        .fdata_in     (fdata_in),
        .fdata_out    (fdata_out)
    );

    always #5 clk = ~clk;

    // SRAM models
    logic [DW-1:0] smem [0:(1<<AW)-1];
    logic [DW-1:0] fmem [0:(1<<AW)-1];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_a = '0;
    logic [DW-1:0] pre_d = '0;

    always @(posedge clk) begin
        if (sload) sdata <= smem[saddr];
        if (fload) fdata_in <= fmem[faddr];
        if (!fstore) fmem[faddr] <= fdata_out;
        else if (pre_we) fmem[pre_a] <= pre_d;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard of expected frame writes
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    wr_t  exp_q[$];
    logic mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en && rst && fstore === 1'b0) begin
            check("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                wr_t w;
                w = exp_q.pop_front();
                $display("[TB] write addr=%0d data=%h (expected addr=%0d data=%h)", faddr, fdata_out, w.a, w.d);
                check("write_addr", 32'(faddr), 32'(w.a));
                check("write_data", fdata_out, w.d);
            end
        end
    end

    // Reference model: pushes expected writes, returns latency and err
    task automatic model(input int fw, input int n, output int lat, output logic e);
        logic [DW-1:0] m [0:63];
        logic [DW-1:0] s, old, nw;
        logic [15:0]   idx;
        int            wa;
        wr_t           w;
        lat = fw + 1;
        e   = 1'b0;
        for (int i = 0; i < fw; i++) begin
            m[i] = '0;
            w.a  = AW'(i);
            w.d  = '0;
            exp_q.push_back(w);
        end
        for (int k = 0; k < n; k++) begin
            s   = smem[k];
            idx = s[31:16];
            wa  = int'(idx >> 1);
            if (wa < fw) begin
                old   = m[wa];
                nw    = idx[0] ? {s[15:0], old[15:0]} : {old[31:16], s[15:0]};
                m[wa] = nw;
                w.a   = AW'(wa);
                w.d   = nw;
                exp_q.push_back(w);
                lat  += 3;
            end else begin
                e    = 1'b1;
                lat += 2;
            end
        end
    endtask

    task automatic preset(input int a, input logic [DW-1:0] d);
        @(negedge clk);
        pre_a  = AW'(a);
        pre_d  = d;
        pre_we = 1'b1;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Pulse enable; returns at the falling edge after the accepting edge
    task automatic start(input int fw, input int n);
        @(negedge clk);
        frame_words  = AW'(fw);
        sample_count = AW'(n);
        enable       = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int busy_at, input int lat,
                             input logic e, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (busy_at > 0 && cyc == busy_at) enable = 1'b1;
            if (busy_at > 0 && cyc == busy_at + 1) enable = 1'b0;
        end
        enable = 1'b0;
        $display("[TB] %s done after %0d cycles err=%b", tag, cyc, err);
        check($sformatf("%s_latency", tag), 32'(cyc), 32'(lat));
        check($sformatf("%s_err", tag), 32'(err), 32'(e));
        check($sformatf("%s_writes_left", tag), 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s_done", tag), 32'(done), 32'd0);
        check($sformatf("%s_err", tag), 32'(err), 32'd0);
        check($sformatf("%s_sload", tag), 32'(sload), 32'd0);
        check($sformatf("%s_fload", tag), 32'(fload), 32'd0);
        check($sformatf("%s_fstore", tag), 32'(fstore), 32'd1);
        check($sformatf("%s_saddr", tag), 32'(saddr), 32'd0);
        check($sformatf("%s_faddr", tag), 32'(faddr), 32'd0);
        check($sformatf("%s_fdata_out", tag), fdata_out, 32'd0);
    endtask

    int   lat, cyc;
    logic e;

    initial begin
        // T1: reset and idle
        repeat (2) @(negedge clk);
        check_reset_outputs("t1_reset");
        rst    = 1'b1;
        mon_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t1_idle_sload", 32'(sload), 32'd0);
            check("t1_idle_fload", 32'(fload), 32'd0);
            check("t1_idle_fstore", 32'(fstore), 32'd1);
        end

        // T2: clear only
        model(8, 0, lat, e);
        start(8, 0);
        wait_done("t2", 0, lat, e, cyc);
        check("t2_cycles", 32'(cyc), 32'd9);
        for (int w = 0; w < 8; w++) check($sformatf("t2_word%0d", w), fmem[w], 32'd0);

        // T3: scatter over a preset word
        preset(2, 32'h0041_0006);
        check("t3_preset", fmem[2], 32'h0041_0006);
        smem[0] = 32'h0005_ABCD;
        smem[1] = 32'h0000_1234;
        model(4, 2, lat, e);
        start(4, 2);
        wait_done("t3", 0, lat, e, cyc);
        check("t3_cycles", 32'(cyc), 32'd11);
        check("t3_word0", fmem[0], 32'h0000_1234);
        check("t3_word1", fmem[1], 32'h0000_0000);
        check("t3_word2", fmem[2], 32'hABCD_0000);
        check("t3_word3", fmem[3], 32'h0000_0000);
        repeat (3) @(negedge clk);
        check("t3_done_held", 32'(done), 32'd1);

        // T4: out-of-range index and duplicate index
        smem[0] = 32'h0004_1111;
        smem[1] = 32'h0001_2222;
        smem[2] = 32'h0001_3333;
        model(2, 3, lat, e);
        start(2, 3);
        wait_done("t4", 0, lat, e, cyc);
        check("t4_err", 32'(err), 32'd1);
        check("t4_cycles", 32'(cyc), 32'd11);
        check("t4_word0", fmem[0], 32'h3333_0000);
        check("t4_word1", fmem[1], 32'h0000_0000);

        // T5: reset during the write phase of the second sample
        preset(2, 32'h0041_0006);
        smem[0] = 32'h0005_ABCD;
        smem[1] = 32'h0000_1234;
        model(4, 2, lat, e);
        start(4, 2);
        repeat (9) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("t5_reset");
        check("t5_writes_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
        check("t5_no_partial_write", fmem[0], 32'd0);
        check("t5_word2_before_reset", fmem[2], 32'hABCD_0000);
        @(negedge clk);
        rst = 1'b1;
        preset(2, 32'h0041_0006);
        model(4, 2, lat, e);
        start(4, 2);
        wait_done("t5_rerun", 0, lat, e, cyc);
        check("t5_cycles", 32'(cyc), 32'd11);
        check("t5_word0", fmem[0], 32'h0000_1234);
        check("t5_word2", fmem[2], 32'hABCD_0000);

        // T6: enable pulse during CLEAR is ignored
        preset(5, 32'hDEAD_BEEF);
        model(8, 0, lat, e);
        start(8, 0);
        wait_done("t6", 3, lat, e, cyc);
        check("t6_cycles", 32'(cyc), 32'd9);
        for (int w = 0; w < 8; w++) check($sformatf("t6_word%0d", w), fmem[w], 32'd0);
        repeat (4) @(negedge clk);
        check("t6_no_restart_done", 32'(done), 32'd1);
        check("t6_no_restart_fstore", 32'(fstore), 32'd1);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
